// File: rtl/wisc_pkg.sv
// wisc_pkg: shared word/PC types and the return-stack operation decode used by ret_addr_stack.
package wisc_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] PC_RST = 16'h0000;
    typedef logic [WORD_W-1:0] pc_t;
    typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPL} ras_op_e;
endpackage

// File: rtl/ras_mem.sv
// ras_mem: DEPTH x AW register array, one synchronous write port and one asynchronous read port.
module ras_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 16,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rdata
);
    logic [AW-1:0] r_mem [DEPTH];
    always_ff @(posedge clk)
        if (we) r_mem[waddr] <= wdata;
    assign rdata = r_mem[raddr];
endmodule

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: hardware return-address stack with zero-cycle top-of-stack read and sticky errors.
// Define RAS_WRAP_EN to let a push while full overwrite the oldest entry instead of being dropped.
module ret_addr_stack
    import wisc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 16,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic          pop,
    output logic [AW-1:0] ret_addr,
    output logic          empty,
    output logic          full,
    output logic [PW:0]   count,
    output logic          ovf_err,
    output logic          unf_err
);
`ifdef RAS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    logic [PW-1:0] r_sp;
    logic [PW:0]   r_count;
    logic          r_ovf, r_unf;
    ras_op_e       w_op;
    logic          w_empty, w_full, w_push_ok, w_pop_ok, w_we;
    logic [PW-1:0] w_top, w_waddr, w_sp_nxt;
    logic [PW:0]   w_count_nxt;
    logic [AW-1:0] w_rdata;
    // push+pop on an empty stack degrades to a plain push (the pop half is flagged as underflow)
    always_comb begin
        w_empty     = r_count == '0;
        w_full      = r_count == FULL_CNT;
        w_top       = r_sp - PW'(1);
        w_op        = !en ? OP_NONE :
                      (push && pop) ? (w_empty ? OP_PUSH : OP_REPL) :
                      push ? OP_PUSH : pop ? OP_POP : OP_NONE;
        w_push_ok   = w_op == OP_PUSH && (!w_full || WRAP);
        w_pop_ok    = w_op == OP_POP && !w_empty;
        w_we        = w_push_ok || w_op == OP_REPL;
        w_waddr     = w_op == OP_REPL ? w_top : r_sp;
        w_sp_nxt    = w_push_ok ? r_sp + PW'(1) : w_pop_ok ? w_top : r_sp;
        w_count_nxt = (w_push_ok && !w_full) ? r_count + (PW+1)'(1) :
                      w_pop_ok ? r_count - (PW+1)'(1) : r_count;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (en) begin
            r_sp    <= w_sp_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= r_ovf | (w_op == OP_PUSH && w_full);
            r_unf   <= r_unf | (pop && w_empty);
        end
    ras_mem #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (push_addr),
        .raddr (w_top),
        .rdata (w_rdata)
    );
    assign ret_addr = w_empty ? AW'(PC_RST) : w_rdata;
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign ovf_err  = r_ovf;
    assign unf_err  = r_unf;
endmodule

// File: tb/tb_ret_addr_stack.sv
// tb_ret_addr_stack: table-driven check of ret_addr_stack plus hand-written overflow and async-reset sequences.
module tb_ret_addr_stack;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, push = 1'b0, pop = 1'b0;
    logic [15:0] push_addr = '0;
    logic [15:0] ret_addr;
    logic        empty, full, ovf_err, unf_err;
    logic [3:0]  count;
    int          checks = 0, failures = 0;

    ret_addr_stack dut (
        .clk(clk), .rst_n(rst_n), .en(en), .push(push), .push_addr(push_addr), .pop(pop),
        .ret_addr(ret_addr), .empty(empty), .full(full), .count(count),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        e, pu, po;
        logic [15:0] a, ret;
        logic [3:0]  cnt;
        logic        unf;
    } vec_t;

    vec_t v [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // inputs change just after the falling edge; outputs are sampled 2ns later, well before the rising edge
    task automatic apply(input logic e, input logic pu, input logic po, input logic [15:0] a);
        @(negedge clk);
        en = e; push = pu; pop = po; push_addr = a;
        #2;
    endtask

    task automatic state(input string tag, input logic [15:0] r, input logic [3:0] c,
                         input logic f, input logic o, input logic u);
        chk({tag, ".ret"},   32'(ret_addr), 32'(r));
        chk({tag, ".count"}, 32'(count),    32'(c));
        chk({tag, ".empty"}, 32'(empty),    32'(c == 4'd0));
        chk({tag, ".full"},  32'(full),     32'(f));
        chk({tag, ".ovf"},   32'(ovf_err),  32'(o));
        chk({tag, ".unf"},   32'(unf_err),  32'(u));
    endtask

    initial begin
        logic [15:0] base;
        // expected values are what the outputs show during the cycle the vector is applied
        v[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0};
        v[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0};
        v[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1};
        v[3]  = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000, 4'd0, 1'b1};
        v[4]  = '{1'b1, 1'b1, 1'b0, 16'h0022, 16'h0011, 4'd1, 1'b1};
        v[5]  = '{1'b1, 1'b1, 1'b0, 16'h0033, 16'h0022, 4'd2, 1'b1};
        v[6]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0033, 4'd3, 1'b1};
        v[7]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0022, 4'd2, 1'b1};
        v[8]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0011, 4'd1, 1'b1};
        v[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1};
        v[10] = '{1'b1, 1'b1, 1'b0, 16'h0AAA, 16'h0000, 4'd0, 1'b1};
        v[11] = '{1'b1, 1'b1, 1'b1, 16'h0BBB, 16'h0AAA, 4'd1, 1'b1};
        v[12] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0BBB, 4'd1, 1'b1};
        v[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1};
        v[14] = '{1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000, 4'd0, 1'b1};
        v[15] = '{1'b0, 1'b1, 1'b0, 16'h0051, 16'h0000, 4'd0, 1'b1};
        v[16] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1};
        v[17] = '{1'b1, 1'b1, 1'b1, 16'h0077, 16'h0000, 4'd0, 1'b1};
        v[18] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0077, 4'd1, 1'b1};
        v[19] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0077, 4'd1, 1'b1};
        v[20] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0077, 4'd1, 1'b1};

        #12;
        state("reset", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            apply(v[i].e, v[i].pu, v[i].po, v[i].a);
            state($sformatf("vec%0d", i), v[i].ret, v[i].cnt, 1'b0, 1'b0, v[i].unf);
        end
        apply(1'b1, 1'b0, 1'b0, 16'h0000);
        state("after_vec", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);

        // overflow: fill, push once more, drain
        rst_n = 1'b0;
        #1;
        state("rst2", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) apply(1'b1, 1'b1, 1'b0, 16'h0100 + 16'(i));
        apply(1'b1, 1'b1, 1'b0, 16'h0108);
        state("full8", 16'h0107, 4'd8, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 16'h0000);
`ifdef RAS_WRAP_EN
        base = 16'h0108;
`else
        base = 16'h0107;
`endif
        state("ovf", base, 4'd8, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b0, 1'b1, 16'h0000);
            chk($sformatf("drain%0d.ret", i), 32'(ret_addr), 32'(base - 16'(i)));
            chk($sformatf("drain%0d.count", i), 32'(count), 32'(8 - i));
        end
        apply(1'b1, 1'b0, 1'b0, 16'h0000);
        state("drained", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);

        // asynchronous reset mid-cycle with live entries and both sticky flags set
        apply(1'b1, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b0, 16'h0200 + 16'(i));
        apply(1'b1, 1'b0, 1'b0, 16'h0000);
        state("pre_arst", 16'h0202, 4'd3, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        state("arst", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b0, 1'b0, 16'h0000);
        state("post_arst", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
